gemm_mem_arbiter: RTL

Shares the single 128-bit GEMM memory interface between two requesters: the load/execute sequencer (tile A/B reads) and the store sequencer (tile C writes). It grants bounded bursts and routes read-return data back to the loader with a fixed-latency tracker. It also drains in-flight reads before handing the bus to a writer. It sits between the two sequencers and the top-level `interface_*` ports of `gemm`.

---
 rtl/gemm_mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/gemm_mem_arbiter.sv
// Shares the 128-bit GEMM memory port between loader reads and store writes; grants are combinational, read data returns RD_LAT cycles after the grant.
// Backpressure: a requester holds req until gnt; bursts stop at MAX_BURST beats. Define GEMM_ARB_STORE_PRIO_EN for fixed store priority.
module gemm_mem_arbiter #(
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_req,
    input  logic [31:0]  ld_addr,
    input  logic [4:0]   ld_control,
    output logic         ld_gnt,
    output logic         ld_rvalid,
    output logic [127:0] ld_rdata,
    input  logic         st_req,
    input  logic [31:0]  st_addr,
    input  logic [4:0]   st_control,
    input  logic [127:0] st_wdata,
    output logic         st_gnt,
    output logic         interface_en,
    output logic         interface_rdwr,
    output logic [31:0]  interface_addr,
    output logic [4:0]   interface_control,
    output logic [127:0] interface_wr_data,
    input  logic [127:0] interface_rd_data,
    output logic [1:0]   owner
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_BURST = 2'd1,
        ST_BURST = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     beat_cnt;
    logic [RD_LAT-1:0] pending;
    logic [RD_LAT-1:0] pending_next;
    logic              last_owner;   // 1 = store finished last
    logic              beat_room;
    logic              last_beat;
    logic              ld_end;
    logic              st_end;
    logic              pick_st;

    assign beat_room    = beat_cnt < CW'(MAX_BURST);
    assign ld_gnt       = (state == LD_BURST) && ld_req && beat_room;
    assign st_gnt       = (state == ST_BURST) && st_req && beat_room;
    assign last_beat    = beat_cnt == CW'(MAX_BURST - 1);
    assign ld_end       = !ld_req || (ld_gnt && last_beat);
    assign st_end       = !st_req || (st_gnt && last_beat);
    assign pending_next = (pending << 1) | RD_LAT'(ld_gnt);

`ifdef GEMM_ARB_STORE_PRIO_EN
    assign pick_st = st_req;
`else
    assign pick_st = st_req && (!ld_req || !last_owner);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 2'd0;
            beat_cnt   <= '0;
            pending    <= '0;
            last_owner <= 1'b1;
        end else begin
            pending <= pending_next;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (pick_st) begin
                        state <= ST_BURST;
                        owner <= 2'd2;
                    end else if (ld_req) begin
                        state <= LD_BURST;
                        owner <= 2'd1;
                    end
                end
                LD_BURST: begin
                    if (ld_gnt) beat_cnt <= beat_cnt + CW'(1);
                    if (ld_end) begin
                        last_owner <= 1'b0;
                        // Reads still in the pipe must land before a writer may take the bus.
                        if (pending_next != '0) begin
                            state <= DRAIN;
                            owner <= 2'd3;
                        end else begin
                            state <= IDLE;
                            owner <= 2'd0;
                        end
                    end
                end
                ST_BURST: begin
                    if (st_gnt) beat_cnt <= beat_cnt + CW'(1);
                    if (st_end) begin
                        last_owner <= 1'b1;
                        state      <= IDLE;
                        owner      <= 2'd0;
                    end
                end
                DRAIN: begin
                    if (pending_next == '0) begin
                        state <= IDLE;
                        owner <= 2'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= 2'd0;
                end
            endcase
        end
    end

    assign interface_en      = ld_gnt | st_gnt;
    assign interface_rdwr    = st_gnt;
    assign interface_addr    = ld_gnt ? ld_addr : (st_gnt ? st_addr : 32'd0);
    assign interface_control = ld_gnt ? ld_control : (st_gnt ? st_control : 5'd0);
    assign interface_wr_data = st_gnt ? st_wdata : 128'd0;

    assign ld_rvalid = pending[RD_LAT-1];
    assign ld_rdata  = ld_rvalid ? interface_rd_data : 128'd0;
endmodule
